weight_rf_db: RTL
=================

Name: weight_rf_db

Overview:
- Parametrised, double-buffered successor to the 16×8-bit shift-loaded weight register file.
- A shadow bank is shift-loaded one word per accepted beat through a valid/ready handshake. Meanwhile the PE array reads a stable active bank.
- A swap request promotes a completely filled shadow bank to active in one cycle. The next weight tile can then stream in while the current tile computes.

Parameters:
- DW, 8, weight word width in bits.
- DEPTH, 16, words per bank (≥2).
- CW, $clog2(DEPTH+1), width of the fill counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  din carries a weight word.
- in_ready  out  1  shadow bank can accept a word.
- din  in  DW  weight word.
- clr  in  1  synchronous abort of the current shadow fill.
- swap_req  in  1  request to promote the shadow bank to active.
- swap_ack  out  1  one-cycle pulse: swap performed.
- swap_err  out  1  one-cycle pulse: swap_req rejected because the shadow bank was not full.
- weight  out  DW*DEPTH  active bank; word i occupies bits [i*DW +: DW].
- weight_vld  out  1  active bank holds a swapped-in tile.
- fill_cnt  out  CW  words loaded into the shadow bank (0..DEPTH).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - both banks all-zero, sel=0, fill_cnt=0, state FILL;
  - weight=0, weight_vld=0, swap_ack=0, swap_err=0, in_ready=1.
- Storage: two banks B0 and B1. The active bank is B[sel] and drives weight combinationally from registers. The shadow bank is B[~sel].
- Accept: a beat is accepted when in_valid && in_ready. On an accepted beat, in the shadow bank only:
  - word[i] <= word[i+1] for i < DEPTH-1;
  - word[DEPTH-1] <= din;
  - fill_cnt increments.
  - After DEPTH beats, the first word accepted sits in word 0.
- State machine:
  - FILL: in_ready=1. An accepted beat that brings fill_cnt to DEPTH moves the block to FULL.
  - FULL: in_ready=0, so din is ignored.
- swap_req is evaluated against the registered state at the start of the cycle:
  - In FULL: next cycle sel toggles, fill_cnt=0, state=FILL, weight_vld=1, and swap_ack pulses for that one cycle. weight reflects the new bank in the same cycle swap_ack is high (one-cycle latency from swap_req).
  - In FILL: no state change; swap_err pulses for one cycle. This includes the cycle in which the last beat is accepted.
- Holding swap_req high across consecutive cycles performs at most one swap per FULL episode.
- clr:
  - In FILL or FULL: fill_cnt<=0, state<=FILL. Shadow data is not zeroed; stale words are shifted out by the next fill.
  - clr has priority over a same-cycle accepted beat (the beat is dropped; in_ready stays 1, and the source must resend).
  - clr has priority over swap_req: no swap, no swap_err.
- The active bank and weight_vld never change except on swap or reset.
- Reset mid-fill or mid-swap returns every output to its reset value immediately (asynchronously).
- With in_valid=0 and no clr/swap, all state holds.

Optional Feature:
- Macro WEIGHT_RF_ZMASK_EN.
- Defined:
  - adds output zmask (DEPTH bits), registered; bit i = (active word i == 0).
  - updated in the same cycle as weight on swap; reset value all-ones.
  - drives PE zero-skipping.
- Undefined: no zmask port and no extra logic; behaviour otherwise identical.

Test Plan:
- Reset then idle: weight=0, weight_vld=0, in_ready=1, fill_cnt=0 (zmask all-ones if enabled).
- Stream 0x01..0x10 with in_valid held high, DW=8/DEPTH=16; then pulse swap_req:
  - in_ready drops after the 16th beat, with fill_cnt=16;
  - one cycle later swap_ack=1, weight_vld=1, word0=0x01, word15=0x10.
- While tile A is active, load tile B=0xF0..0xFF with random in_valid gaps, then swap:
  - weight stays tile A until the swap_ack cycle;
  - then word0=0xF0, word15=0xFF.
- swap_req at fill_cnt=5, and again in the same cycle the 16th beat is accepted: swap_err pulses each time, sel unchanged; a swap_req one cycle later succeeds.
- clr at fill_cnt=9 with a simultaneous beat:
  - fill_cnt=0 next cycle and the beat is dropped;
  - then 16 new beats fill and swap correctly with no stale data in words 0..15.
- Assert rst_n=0 mid-fill (fill_cnt=7) with weight_vld=1: all outputs return to reset values immediately. With WEIGHT_RF_ZMASK_EN, also check a tile with zeros in words 3 and 12 gives zmask=16'h1008 after swap.

Source files
------------

// File: rtl/weight_rf_db.sv
// Double-buffered weight register file: shift-load a shadow bank while the PE array reads the active bank.
// Optional WEIGHT_RF_ZMASK_EN adds a registered per-word zero mask of the active bank.
module weight_rf_db #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       din,
  input  logic                clr,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                swap_err,
  output logic [DW*DEPTH-1:0] weight,
  output logic                weight_vld,
  output logic [CW-1:0]       fill_cnt
`ifdef WEIGHT_RF_ZMASK_EN
  ,
  output logic [DEPTH-1:0]    zmask
`endif
);

  localparam int WW = DW * DEPTH;

  // state | meaning
  // FILL  | shadow bank accepting words, in_ready=1
  // FULL  | shadow bank holds DEPTH words, waiting for swap
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic            sel;
  logic [WW-1:0]   bank0, bank1;
  logic [WW-1:0]   shadow, shifted;
  logic            accept, do_swap;

  assign shadow   = sel ? bank0 : bank1;
  assign weight   = sel ? bank1 : bank0;
  assign in_ready = (state == FILL);
  assign accept   = in_valid && in_ready;
  assign do_swap  = !clr && swap_req && (state == FULL);
  // Oldest word drifts toward word 0; new word enters at the top.
  assign shifted  = {din, shadow[WW-1:DW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      sel        <= 1'b0;
      bank0      <= '0;
      bank1      <= '0;
      fill_cnt   <= '0;
      weight_vld <= 1'b0;
      swap_ack   <= 1'b0;
      swap_err   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      swap_err <= 1'b0;
      if (clr) begin
        fill_cnt <= '0;
        state    <= FILL;
      end else begin
        if (swap_req) begin
          if (state == FULL) begin
            sel        <= ~sel;
            fill_cnt   <= '0;
            state      <= FILL;
            weight_vld <= 1'b1;
            swap_ack   <= 1'b1;
          end else begin
            swap_err <= 1'b1;
          end
        end
        // accept implies FILL, so it never collides with a successful swap
        if (accept) begin
          if (sel) bank0 <= shifted;
          else     bank1 <= shifted;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == CW'(DEPTH - 1)) state <= FULL;
        end
      end
    end
  end

`ifdef WEIGHT_RF_ZMASK_EN
  logic [DEPTH-1:0] zmask_next;

  always_comb begin
    zmask_next = '0;
    for (int i = 0; i < DEPTH; i++) zmask_next[i] = (shadow[i*DW +: DW] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       zmask <= '1;
    else if (do_swap) zmask <= zmask_next;
  end
`else
  logic unused_swap;
  assign unused_swap = do_swap;
`endif

endmodule
